// File: rtl/fcmp_pkg.sv
// Shared types and helpers for the shared float-compare arbiter.
// Holds the op encoding, binary32 constants and the NaN test.
package fcmp_pkg;

  typedef enum logic [1:0] {
    FEQ = 2'b00,
    FLT = 2'b01,
    FLE = 2'b10,
    RSV = 2'b11
  } fcmp_op_t;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  function automatic logic is_nan(logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational binary32 compare: FEQ/FLT/FLE with NaN and reserved-op flags.
// Denormals compare by raw bits; -0 and +0 are equal.
module fcmp_core
  import fcmp_pkg::*;
(
  input  logic [31:0] x1_i,
  input  logic [31:0] x2_i,
  input  logic [1:0]  op_i,
  output logic        y_o,
  output logic        nan_o,
  output logic        err_o
);

  fcmp_op_t op;
  logic     any_nan;
  logic     both_zero;
  logic     eq;
  logic     lt;

  always_comb begin
    op        = fcmp_op_t'(op_i);
    any_nan   = is_nan(x1_i) | is_nan(x2_i);
    both_zero = (x1_i[30:0] == 31'd0) && (x2_i[30:0] == 31'd0);
    eq        = (x1_i == x2_i) | both_zero;

    // Sign-magnitude ordering: negative magnitudes order in reverse.
    if (both_zero)                lt = 1'b0;
    else if (x1_i[31] != x2_i[31]) lt = x1_i[31];
    else if (x1_i[31])            lt = x1_i[30:0] > x2_i[30:0];
    else                          lt = x1_i[30:0] < x2_i[30:0];

    y_o   = 1'b0;
    nan_o = 1'b0;
    err_o = 1'b0;
    case (op)
      FEQ:     y_o = eq;
      FLT:     y_o = lt;
      FLE:     y_o = lt | eq;
      default: err_o = 1'b1;
    endcase

    if ((op != RSV) && any_nan) begin
      y_o   = 1'b0;
      nan_o = 1'b1;
    end
  end

endmodule

// File: rtl/fcmp_arbiter.sv
// Round-robin share of one float-compare datapath among N requesters,
// with a single registered result stage (1-cycle latency).
module fcmp_arbiter
  import fcmp_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [2*N-1:0]  req_op,
  input  logic [32*N-1:0] req_x1,
  input  logic [32*N-1:0] req_x2,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [IDW-1:0]  res_id,
  output logic            res_y,
  output logic            res_nan,
  output logic            res_err
);

  // Handshake: a request on port p transfers when req_valid[p] & req_ready[p];
  // the result transfers when res_valid & res_ready. req_ready is only raised
  // when the result register is empty or being popped in the same cycle.

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant;
  logic [IDW:0]   idx_w;
  logic [IDW-1:0] idx;
  logic           found;
  logic           can_issue;
  logic           fire;

  logic           res_valid_q, res_valid_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_y_q, res_y_d;
  logic           res_nan_q, res_nan_d;
  logic           res_err_q, res_err_d;

  logic [1:0]     sel_op;
  logic [31:0]    sel_x1;
  logic [31:0]    sel_x2;
  logic           core_y, core_nan, core_err;

  always_comb begin : grant_search
    found = 1'b0;
    grant = '0;
    idx_w = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx_w = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (idx_w >= (IDW+1)'(N)) idx_w = idx_w - (IDW+1)'(N);
      idx = idx_w[IDW-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign can_issue = !res_valid_q || res_ready;
  assign fire      = found && can_issue && !rst;

  always_comb begin : operand_mux
    req_ready = '0;
    sel_op    = '0;
    sel_x1    = '0;
    sel_x2    = '0;
    for (int p = 0; p < N; p++) begin
      if (grant == IDW'(p)) begin
        req_ready[p] = fire;
        sel_op       = req_op[2*p +: 2];
        sel_x1       = req_x1[32*p +: 32];
        sel_x2       = req_x2[32*p +: 32];
      end
    end
  end

  fcmp_core u_core (
    .x1_i  (sel_x1),
    .x2_i  (sel_x2),
    .op_i  (sel_op),
    .y_o   (core_y),
    .nan_o (core_nan),
    .err_o (core_err)
  );

  always_comb begin : next_state
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_y_d     = res_y_q;
    res_nan_d   = res_nan_q;
    res_err_d   = res_err_q;
    rr_ptr_d    = rr_ptr_q;
    if (fire) begin
      res_valid_d = 1'b1;
      res_id_d    = grant;
      res_y_d     = core_y;
      res_nan_d   = core_nan;
      res_err_d   = core_err;
      rr_ptr_d    = (grant == IDW'(N-1)) ? '0 : grant + IDW'(1);
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_y_q     <= 1'b0;
      res_nan_q   <= 1'b0;
      res_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_y_q     <= res_y_d;
      res_nan_q   <= res_nan_d;
      res_err_q   <= res_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_y     = res_y_q;
  assign res_nan   = res_nan_q;
  assign res_err   = res_err_q;

endmodule

// File: doc/fcmp_arbiter.md
Name: fcmp_arbiter

Overview:
Shares one combinational float-compare datapath (FEQ/FLT/FLE, binary32) among N requesters, e.g. FPU issue slots.
Arbitration is round-robin with per-port valid/ready handshakes. The block produces one registered result per accepted request, with the winning port index, an unordered (NaN) flag and an illegal-op flag.
It sits between the FPU issue logic and the integer writeback path.

Parameters:
N, 4, number of requesters (2..8)
IDW, $clog2(N), width of the port index

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  N  per-port request valid
req_ready  out  N  per-port accept (one-hot or zero)
req_op  in  2*N  per-port op, port p at [2p+1:2p]
req_x1  in  32*N  per-port operand 1, port p at [32p+31:32p]
req_x2  in  32*N  per-port operand 2
res_valid  out  1  result register holds a result
res_ready  in  1  consumer accepts the result
res_id  out  IDW  port index that issued the result
res_y  out  1  comparison result
res_nan  out  1  at least one operand is NaN
res_err  out  1  op was reserved (2'b11)

Behaviour:
- Reset (async, rst=1): res_valid=0, res_id=0, res_y=0, res_nan=0, res_err=0, rr_ptr=0, req_ready=0. All outputs are registered except req_ready.
- Op encoding: 00 FEQ, 01 FLT, 10 FLE, 11 reserved.
- NaN test: exp==8'hFF and mantissa!=0, for either operand.
- Infinities compare as ordered values.
- Zeros: -0 and +0 are equal. FEQ=1, FLE=1, FLT=0.
- Otherwise use sign-magnitude ordering.
- If either operand is NaN: y=0 for all ops, and nan=1.
- Reserved op: y=0, nan=0, err=1.
- Denormals compare by raw bits. No flush.
- Stage credit: can_issue = !res_valid | res_ready (combinational).
- Grant: the first p with req_valid[p]=1, searched from rr_ptr upward, wrapping modulo N.
- req_ready = onehot(grant) only when can_issue=1 and some request is valid; otherwise req_ready=0.
- Handshake: a transfer on port p occurs when req_valid[p] & req_ready[p].
- Latency: exactly 1 cycle. On a transfer, at the next edge res_valid=1 and res_id/res_y/res_nan/res_err are loaded.
- Pointer: on a transfer, rr_ptr <= (grant+1) mod N. With no transfer, rr_ptr holds.
- Result hold: while res_valid=1 and res_ready=0, the result register and rr_ptr are frozen and req_ready=0.
- Simultaneous pop and push: res_valid=1, res_ready=1 and a new grant gives back-to-back results at one per cycle with no bubble.
- Pop with no new request: res_valid<=0.
- Requester rules: once asserted, req_valid and its payload stay stable until accepted. The block does not check this; a violation is a bench error.
- Reset mid-operation: any pending result is discarded and no port is granted during reset.
- rst deassertion is synchronised externally.

Decomposition:
- Package fcmp_pkg holds:
  - typedef fcmp_op_t (enum FEQ/FLT/FLE/RSV, 2 bits)
  - constants EXP_MAX=8'hFF and QNAN=32'h7FC00000 for benches
  - function is_nan(logic [31:0])
- Sub-module fcmp_core is purely combinational: (x1, x2, op) -> (y, nan, err).
- The arbiter module holds the RR grant, pointer and result register.

Test Plan:
1. Single port 0: FLE x1=0x3F800000 (1.0), x2=0x40000000 (2.0) -> next cycle res_valid=1, res_id=0, res_y=1, res_nan=0. With FLT and the operands swapped -> res_y=0.
2. Zeros and NaN:
   - FEQ 0x80000000 vs 0x00000000 -> res_y=1.
   - FLE 0x7FC00000 vs 0x3F800000 -> res_y=0, res_nan=1.
   - FLE 0x7F800000 vs 0x7F800000 -> res_y=1, res_nan=0.
3. Round-robin: all 4 ports valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle, res_id matching each cycle.
4. Backpressure: res_ready=0 for 3 cycles with ports 1 and 2 valid -> req_ready=0 and the result held stable. On release, the held result pops and port 2 is granted the same cycle, followed by port 1 (rr_ptr was 2).
5. Reserved op 2'b11 on port 3 -> res_err=1, res_y=0, res_nan=0.
6. Reset: assert rst while res_valid=1 and ports valid -> res_valid=0 and req_ready=0 immediately (async). After release, the first grant goes to the lowest valid port (rr_ptr=0).
7. Random soak against a shortreal reference model with the NaN/zero corner operands. No mismatches, no lost or duplicated requests.
